// File: rtl/down_pwl_pack.sv
// Eight-lane piecewise-linear compander: signed 8-bit samples -> 6-bit {sign, code}.
// Two-stage valid/ready pipeline plus a saturating count of clipped samples.
module down_pwl_pack #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arstb,
  input  logic             rstb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      code_out,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  // Handshake: a vector moves on any edge where valid && ready are both high.
  // Stage B loads whenever it is empty or being drained; stage A advances only
  // when stage B loads, so in_ready never depends on in_valid.

  localparam int LANES = 8;

  logic                  r_a_valid;
  logic [LANES-1:0]      r_a_sign;
  logic [LANES-1:0][7:0] r_a_mag;
  logic [LANES-1:0]      r_a_sat;

  logic                  r_b_valid;
  logic [47:0]           r_code;

  logic [CNT_W-1:0]      r_sat_cnt;

  logic                  w_b_load;
  logic                  w_in_xfer;
  logic [LANES-1:0]      w_sign;
  logic [LANES-1:0][7:0] w_mag;
  logic [LANES-1:0]      w_sat;
  logic [3:0]            w_sat_num;
  logic [CNT_W:0]        w_sat_sum;
  logic [47:0]           w_code;

  function automatic logic [4:0] pwl_code(input logic [7:0] m);
    logic [4:0] c;
    if (m < 8'd8)
      c = m[4:0];
    else if (m < 8'd24)
      c = 5'(8'd8 + ((m - 8'd8) >> 1));
    else if (m < 8'd56)
      c = 5'(8'd16 + ((m - 8'd24) >> 2));
    else if (m < 8'd120)
      c = 5'(8'd24 + ((m - 8'd56) >> 3));
    else
      c = 5'd31;
    return c;
  endfunction

  assign w_b_load  = !r_b_valid || out_ready;
  assign in_ready  = !r_a_valid || w_b_load;
  assign w_in_xfer = in_valid && in_ready;

  // Magnitude of -128 is 128, which fits the unsigned 8-bit field.
  always_comb begin
    w_sign    = '0;
    w_mag     = '0;
    w_sat     = '0;
    w_sat_num = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sign[i] = x_in[8*i+7];
      w_mag[i]  = w_sign[i] ? (8'd0 - x_in[8*i +: 8]) : x_in[8*i +: 8];
      w_sat[i]  = (w_mag[i] >= 8'd120);
      w_sat_num = w_sat_num + {3'b000, w_sat[i]};
    end
  end

  assign w_sat_sum = {1'b0, r_sat_cnt} + (CNT_W+1)'(w_sat_num);

  always_comb begin
    w_code = '0;
    for (int i = 0; i < LANES; i++) begin
      w_code[6*i +: 6] = {r_a_sign[i], (r_a_sat[i] ? 5'd31 : pwl_code(r_a_mag[i]))};
    end
  end

  // Stage A: sign, magnitude and saturation flags of the accepted vector.
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      r_a_valid <= 1'b0;
      r_a_sign  <= '0;
      r_a_mag   <= '0;
      r_a_sat   <= '0;
    end else if (!rstb) begin
      r_a_valid <= 1'b0;
      r_a_sign  <= '0;
      r_a_mag   <= '0;
      r_a_sat   <= '0;
    end else if (in_ready) begin
      r_a_valid <= in_valid;
      if (in_valid) begin
        r_a_sign <= w_sign;
        r_a_mag  <= w_mag;
        r_a_sat  <= w_sat;
      end
    end
  end

  // Stage B: output registers, held while downstream stalls.
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      r_b_valid <= 1'b0;
      r_code    <= '0;
    end else if (!rstb) begin
      r_b_valid <= 1'b0;
      r_code    <= '0;
    end else if (w_b_load) begin
      r_b_valid <= r_a_valid;
      if (r_a_valid)
        r_code <= w_code;
    end
  end

  // Clear wins over a simultaneous saturated transfer; the count sticks at all-ones.
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb)
      r_sat_cnt <= '0;
    else if (!rstb || sat_clr)
      r_sat_cnt <= '0;
    else if (w_in_xfer)
      r_sat_cnt <= w_sat_sum[CNT_W] ? {CNT_W{1'b1}} : w_sat_sum[CNT_W-1:0];
  end

  assign out_valid = r_b_valid;
  assign code_out  = r_code;
  assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_down_pwl_pack.sv
// Bench for down_pwl_pack: directed steps plus random traffic against a
// queue-based reference model; two instances (CNT_W=16 and CNT_W=4) share stimulus.
module tb_down_pwl_pack;

  logic        clk = 1'b0;
  logic        arstb, rstb, in_valid, out_ready, sat_clr;
  logic [63:0] x_in;
  logic        in_ready, out_valid;
  logic [47:0] code_out;
  logic [15:0] sat_cnt;
  logic        in_ready4, out_valid4;
  logic [47:0] code_out4;
  logic [3:0]  sat_cnt4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [47:0] exp_q[$];
  int          stamp_q[$];
  int          m16, m4;
  logic        hold_v;
  logic [47:0] hold_code;
  logic        last_acc;
  logic        saw_block;

  down_pwl_pack dut (
    .clk(clk), .arstb(arstb), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .out_valid(out_valid), .out_ready(out_ready), .code_out(code_out),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  down_pwl_pack #(.CNT_W(4)) dut4 (
    .clk(clk), .arstb(arstb), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready4),
    .x_in(x_in), .out_valid(out_valid4), .out_ready(out_ready), .code_out(code_out4),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt4)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // reference model
  function automatic int ref_code(int x);
    int m, c;
    m = (x < 0) ? -x : x;
    if (m < 8)        c = m;
    else if (m < 24)  c = 8 + (m - 8) / 2;
    else if (m < 56)  c = 16 + (m - 24) / 4;
    else if (m < 120) c = 24 + (m - 56) / 8;
    else              c = 31;
    return ((x < 0) ? 32 : 0) + c;
  endfunction

  function automatic logic [47:0] ref_vec(logic [63:0] v);
    logic [47:0]        r;
    logic signed [7:0]  b;
    int                 x;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      b = v[8*i +: 8];
      x = b;
      r[6*i +: 6] = 6'(ref_code(x));
    end
    return r;
  endfunction

  function automatic int ref_sat(logic [63:0] v);
    logic signed [7:0] b;
    int                x, n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      b = v[8*i +: 8];
      x = b;
      if (x >= 120 || x <= -120) n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    stamp_q.delete();
    m16    = 0;
    m4     = 0;
    hold_v = 1'b0;
  endtask

  // driver + scoreboard: inputs are set at negedge, sampled #1 later, one edge per call
  task automatic cycle();
    logic acc, dlv;
    logic exp_ov;
    logic [47:0] e;
    int n;
    #1;
    exp_ov = (exp_q.size() > 0) && (cyc - stamp_q[0] >= 2);
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
    chk("out_valid4", {63'd0, out_valid4}, {63'd0, exp_ov});
    chk("in_ready", {63'd0, in_ready}, {63'd0, !(exp_q.size() >= 2 && !out_ready)});
    chk("in_ready4", {63'd0, in_ready4}, {63'd0, !(exp_q.size() >= 2 && !out_ready)});
    if (hold_v) begin
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_code", {16'd0, code_out}, {16'd0, hold_code});
    end
    if (in_valid && !in_ready) saw_block = 1'b1;
    acc = in_valid && in_ready && rstb && arstb;
    dlv = out_valid && out_ready && rstb && arstb;
    if (dlv) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        void'(stamp_q.pop_front());
        chk("code_out", {16'd0, code_out}, {16'd0, e});
        chk("code_out4", {16'd0, code_out4}, {16'd0, e});
      end
    end
    if (acc) begin
      exp_q.push_back(ref_vec(x_in));
      stamp_q.push_back(cyc);
    end
    hold_v    = out_valid && !out_ready && rstb && arstb;
    hold_code = code_out;
    n = acc ? ref_sat(x_in) : 0;
    if (!rstb || !arstb) begin
      model_clear();
    end else if (sat_clr) begin
      m16 = 0;
      m4  = 0;
    end else begin
      m16 = (m16 + n > 65535) ? 65535 : m16 + n;
      m4  = (m4 + n > 15) ? 15 : m4 + n;
    end
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
    chk("sat_cnt", {48'd0, sat_cnt}, 64'(m16));
    chk("sat_cnt4", {60'd0, sat_cnt4}, 64'(m4));
  endtask

  function automatic logic [63:0] fill(logic [7:0] b);
    return {8{b}};
  endfunction

  int          enc_x[8]     = '{5, -20, 100, -128, 127, 119, 24, 55};
  int          enc_codes[8] = '{5, 46, 29, 63, 31, 31, 16, 23};
  logic [63:0] bp_vec[6];
  logic [47:0] enc_exp;
  int          idx, k;

  initial begin
    arstb = 1'b0; rstb = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    x_in = '0; last_acc = 1'b0; saw_block = 1'b0;
    model_clear();
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_code", {16'd0, code_out}, 64'd0);
    chk("rst_sat", {48'd0, sat_cnt}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    arstb = 1'b1; rstb = 1'b1;

    // encoding sweep of the documented lanes
    for (int i = 0; i < 8; i++) begin
      x_in[8*i +: 8] = 8'(enc_x[i]);
      enc_exp[6*i +: 6] = 6'(enc_codes[i]);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("enc_valid", {63'd0, out_valid}, 64'd1);
    chk("enc_code", {16'd0, code_out}, {16'd0, enc_exp});
    chk("enc_sat", {48'd0, sat_cnt}, 64'd2);
    cycle();

    // every 8-bit value on every lane
    for (int v = 0; v < 256; v++) begin
      for (int i = 0; i < 8; i++) x_in[8*i +: 8] = 8'((v + 32*i) % 256);
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();

    // backpressure: six vectors, out_ready low for three cycles mid-stream
    for (int i = 0; i < 6; i++) bp_vec[i] = {$urandom, $urandom};
    idx = 0; k = 0; saw_block = 1'b0;
    while ((idx < 6 || exp_q.size() > 0) && k < 40) begin
      out_ready = !(k >= 2 && k < 5);
      in_valid  = (idx < 6);
      x_in      = bp_vec[(idx < 6) ? idx : 5];
      cycle();
      if (last_acc) idx++;
      k++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_block", {63'd0, saw_block}, 64'd1);
    chk("bp_sent", 64'(idx), 64'd6);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // narrow counter saturation and clear priority
    rstb = 1'b0;
    cycle();
    rstb = 1'b1;
    x_in = fill(8'h80); in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    chk("cnt4_8", {60'd0, sat_cnt4}, 64'd8);
    cycle();
    chk("cnt4_15", {60'd0, sat_cnt4}, 64'd15);
    cycle();
    chk("cnt4_hold", {60'd0, sat_cnt4}, 64'd15);
    sat_clr = 1'b1;
    cycle();
    chk("cnt4_clr", {60'd0, sat_cnt4}, 64'd0);
    chk("cnt16_clr", {48'd0, sat_cnt}, 64'd0);
    sat_clr = 1'b0; in_valid = 1'b0;
    repeat (3) cycle();

    // synchronous reset with two vectors in flight
    x_in = fill(8'h7F); in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    x_in = fill(8'h81);
    cycle();
    rstb = 1'b0; x_in = fill(8'h80);
    cycle();
    chk("srst_valid", {63'd0, out_valid}, 64'd0);
    chk("srst_code", {16'd0, code_out}, 64'd0);
    chk("srst_sat", {48'd0, sat_cnt}, 64'd0);
    rstb = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    // asynchronous reset mid-cycle with two vectors in flight
    x_in = fill(8'h90); in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    x_in = fill(8'h11);
    cycle();
    in_valid = 1'b0;
    #2 arstb = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_code", {16'd0, code_out}, 64'd0);
    chk("arst_sat", {48'd0, sat_cnt}, 64'd0);
    chk("arst_ready", {63'd0, in_ready}, 64'd1);
    model_clear();
    @(negedge clk);
    in_valid = 1'b1;
    cycle();
    arstb = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    // random traffic
    in_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        x_in     = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 9) < 7);
      sat_clr   = ($urandom_range(0, 15) == 0);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    repeat (5) cycle();
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/down_pwl_pack.md
DOWN_PWL_PACK -- requirements
Module: down_pwl_pack

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of saturation counter sat_cnt.
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port arstb, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port rstb, input, 1, synchronous clear, active-low, sampled on clk.
REQ-005 SHALL have port in_valid, input, 1, input vector present.
REQ-006 SHALL have port in_ready, output, 1, block accepts vector this cycle.
REQ-007 SHALL have port x_in, input, 64, eight signed 8-bit samples; lane i = x_in[8i+7:8i].
REQ-008 SHALL have port out_valid, output, 1, code vector present.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts code vector.
REQ-010 SHALL have port code_out, output, 48, eight 6-bit PWL codes; lane i = code_out[6i+5:6i].
REQ-011 SHALL have port sat_clr, input, 1, synchronous clear of sat_cnt.
REQ-012 SHALL have port sat_cnt, output, CNT_W, count of saturated samples accepted.

Function
REQ-013 SHALL encode each lane independently: sign s = x[7]; magnitude m = |x| as 8-bit unsigned (m=128 for -128).
REQ-014 SHALL map m to 5-bit code c: m 0..7 -> c=m; 8..23 -> 8+((m-8)>>1); 24..55 -> 16+((m-24)>>2); 56..119 -> 24+((m-56)>>3); m>=120 -> c=31.
REQ-015 SHALL form lane code {s, c}; a lane is saturated when m>=120; code 6'b100000 is never produced.
REQ-016 SHALL be a 2-stage pipeline: stage A registers sign, magnitude, saturation flags; stage B (output registers) holds code_out.
REQ-017 SHALL transfer input when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-018 SHALL load stage B when !out_valid || out_ready; stage A advances only when stage B loads.
REQ-019 SHALL drive in_ready = !a_valid || b_load (combinational from internal state and out_ready; no dependence on in_valid).
REQ-020 SHALL give latency 2 cycles accept-to-out_valid with out_ready held high; throughput 1 vector/cycle.
REQ-021 SHALL hold code_out and out_valid stable while out_valid && !out_ready; no vector dropped or duplicated.
REQ-022 SHALL increment sat_cnt on each input transfer by the number of saturated lanes (0..8) in that vector.
REQ-023 SHALL saturate sat_cnt at 2^CNT_W-1 (no wrap).
REQ-024 SHALL give sat_clr priority over increment: simultaneous sat_clr and saturated transfer -> sat_cnt = 0.
REQ-025 SHALL update sat_cnt on the same edge as the input transfer (visible next cycle).

Reset
REQ-026 SHALL on arstb low asynchronously force out_valid=0, code_out=0, sat_cnt=0, stage A valid=0.
REQ-027 SHALL on rstb low at a clock edge force the same values as REQ-026, discarding in-flight vectors.
REQ-028 SHALL drive in_ready=1 during and immediately after reset (pipeline empty).
REQ-029 SHALL ignore in_valid in any cycle where rstb is low; no transfer counted.

Verification
REQ-030 Encoding sweep: lanes x = 5, -20, 100, -128, 127, 119, 24, 55 with out_ready=1 -> 2 cycles later code_out lanes = 5, 46, 29, 63, 31, 31, 16, 23; sat_cnt increments by 2.
REQ-031 Full sweep: all 256 values of x on every lane -> codes match REQ-014 model; monotonic non-decreasing c with m.
REQ-032 Backpressure: stream 6 vectors, out_ready low for 3 cycles mid-stream -> out_valid held, code_out stable, in_ready drops after pipeline fills, all 6 vectors delivered in order.
REQ-033 Counter: CNT_W=4, feed vectors of eight x=-128 -> sat_cnt 8, then 15, stays 15; assert sat_clr with saturated transfer -> sat_cnt 0.
REQ-034 Reset mid-operation: 2 vectors in flight, pulse rstb low 1 cycle -> out_valid=0, sat_cnt=0 next cycle, no stale vector emitted; repeat with arstb asynchronously mid-cycle -> outputs zero immediately.
